// File: rtl/cipher_iter_param_pkg.sv
// Shared constants, state encoding and PRESENT-80 layer functions for cipher_iter_param.
// Inverse layers are only referenced when CIPHER_ITER_DEC_EN is defined.
package cipher_iter_param_pkg;

    localparam int N_K = 80;
    localparam int N_B = 64;
    localparam int N_R = 31;

    typedef enum logic [1:0] {IDLE, KEXP, RUN, DONE} state_t;

    // Nibble tables, entry x sits at bits [4x+3:4x]
    localparam logic [63:0] SBOX_T     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_T = 64'hA970_364B_D21C_8FE5;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_T[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_T[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [N_B-1:0] s_layer(input logic [N_B-1:0] x);
        logic [N_B-1:0] y;
        for (int i = 0; i < N_B / 4; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [N_B-1:0] inv_s_layer(input logic [N_B-1:0] x);
        logic [N_B-1:0] y;
        for (int i = 0; i < N_B / 4; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put
    function automatic logic [N_B-1:0] p_layer(input logic [N_B-1:0] x);
        logic [N_B-1:0] y;
        for (int i = 0; i < N_B - 1; i++) y[(16 * i) % 63] = x[i];
        y[N_B-1] = x[N_B-1];
        return y;
    endfunction

    function automatic logic [N_B-1:0] inv_p_layer(input logic [N_B-1:0] x);
        logic [N_B-1:0] y;
        for (int i = 0; i < N_B - 1; i++) y[i] = x[(16 * i) % 63];
        y[N_B-1] = x[N_B-1];
        return y;
    endfunction

    function automatic logic [N_K-1:0] key_update(input logic [N_K-1:0] kin, input logic [4:0] rc);
        logic [N_K-1:0] t;
        t = {kin[18:0], kin[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [N_K-1:0] key_update_inv(input logic [N_K-1:0] kin, input logic [4:0] rc);
        logic [N_K-1:0] t;
        t = kin;
        t[19:15] = t[19:15] ^ rc;
        t[79:76] = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/cipher_iter_param_round.sv
// One combinational PRESENT-80 round with key update; passes through when en=0.
// The decrypt branch exists only when CIPHER_ITER_DEC_EN is defined.
module cipher_round
    import cipher_iter_param_pkg::*;
(
    input  logic           dec,
    input  logic           en,
    input  logic [4:0]     idx,
    input  logic [N_B-1:0] st_in,
    input  logic [N_K-1:0] key_in,
    output logic [N_B-1:0] st_out,
    output logic [N_K-1:0] key_out
);

    always_comb begin
        st_out  = st_in;
        key_out = key_in;
        if (en) begin
`ifdef CIPHER_ITER_DEC_EN
            if (dec) begin
                // Walk the key back to K_idx, then strip it after the inverse layers
                key_out = key_update_inv(key_in, idx);
                st_out  = inv_s_layer(inv_p_layer(st_in)) ^ key_out[N_K-1:16];
            end else
`endif
            begin
                st_out  = p_layer(s_layer(st_in ^ key_in[N_K-1:16]));
                key_out = key_update(key_in, idx);
            end
        end
    end

`ifndef CIPHER_ITER_DEC_EN
    logic unused_dec;
    assign unused_dec = dec;
`endif

endmodule

// File: rtl/cipher_iter_param.sv
// Iterative PRESENT-80 engine, UNROLL rounds per clock, 4-phase req/ack handshake.
// Define CIPHER_ITER_DEC_EN to enable decryption (KEXP state + inverse datapath).
module cipher_iter_param
    import cipher_iter_param_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    output logic           ack,
    input  logic           dec,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] m,
    output logic [N_B-1:0] c
);

    state_t                   state, state_nx;
    logic [4:0]               ctr;
    logic [N_B-1:0]           st;
    logic [N_K-1:0]           key;
    logic                     run_dec;
    logic                     last;
    logic [UNROLL:0][N_B-1:0] st_ch;
    logic [UNROLL:0][N_K-1:0] key_ch;

`ifdef CIPHER_ITER_DEC_EN
    logic dec_r;
    assign run_dec = dec_r && (state == RUN);
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign run_dec    = 1'b0;
`endif

    // Decryption opens with the K32 whitening before the first inverse round
    assign st_ch[0]  = (run_dec && ctr == 5'(N_R)) ? (st ^ key[N_K-1:16]) : st;
    assign key_ch[0] = key;

    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        int ri;
        assign ri = run_dec ? (int'(ctr) - j) : (int'(ctr) + j);
        cipher_round u_round (
            .dec     (run_dec),
            .en      (ri >= 1 && ri <= N_R),
            .idx     (5'(ri)),
            .st_in   (st_ch[j]),
            .key_in  (key_ch[j]),
            .st_out  (st_ch[j+1]),
            .key_out (key_ch[j+1])
        );
    end

    always_comb begin
        if (run_dec) last = (int'(ctr) - UNROLL) < 1;
        else         last = (int'(ctr) + UNROLL) > N_R;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = RUN;
`ifdef CIPHER_ITER_DEC_EN
                    if (dec) state_nx = KEXP;
`endif
                end
            end
            KEXP:    if (last) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (!req) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ack   <= 1'b0;
            c     <= '0;
            ctr   <= '0;
            st    <= '0;
            key   <= '0;
`ifdef CIPHER_ITER_DEC_EN
            dec_r <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req) begin
                        st    <= m;
                        key   <= k;
                        ctr   <= 5'd1;
`ifdef CIPHER_ITER_DEC_EN
                        dec_r <= dec;
`endif
                    end
                end
                KEXP: begin
                    key <= key_ch[UNROLL];
                    ctr <= last ? 5'(N_R) : ctr + 5'(UNROLL);
                end
                RUN: begin
                    st  <= st_ch[UNROLL];
                    key <= key_ch[UNROLL];
                    ctr <= run_dec ? ctr - 5'(UNROLL) : ctr + 5'(UNROLL);
                    if (last) begin
                        ack <= 1'b1;
                        c   <= run_dec ? st_ch[UNROLL] : (st_ch[UNROLL] ^ key_ch[UNROLL][N_K-1:16]);
                    end
                end
                DONE: if (!req) ack <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
